// File: rtl/div_share_arbiter.sv
// div_share_arbiter: round-robin share of one iterative divider between K_NREQ requesters.
// Ports: i_clk/i_rst (sync, active-high); i_req_valid/o_req_ready request handshake;
// i_req_x/i_req_y packed operands; o_done one-hot completion pulse; o_q/o_r/o_dbz/o_err result
// of last op; o_div_start/o_div_x/o_div_y to divider; i_div_busy/valid/dbz/q/r from divider.
module div_share_arbiter #(
    parameter int K_NREQ    = 3,
    parameter int K_WIDTH   = 8,
    parameter int K_TIMEOUT = 64
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [K_NREQ-1:0]           i_req_valid,
    output logic [K_NREQ-1:0]           o_req_ready,
    input  logic [K_NREQ*K_WIDTH-1:0]   i_req_x,
    input  logic [K_NREQ*K_WIDTH-1:0]   i_req_y,
    output logic [K_NREQ-1:0]           o_done,
    output logic [K_WIDTH-1:0]          o_q,
    output logic [K_WIDTH-1:0]          o_r,
    output logic                        o_dbz,
    output logic                        o_err,
    output logic                        o_div_start,
    output logic [K_WIDTH-1:0]          o_div_x,
    output logic [K_WIDTH-1:0]          o_div_y,
    input  logic                        i_div_busy,
    input  logic                        i_div_valid,
    input  logic                        i_div_dbz,
    input  logic [K_WIDTH-1:0]          i_div_q,
    input  logic [K_WIDTH-1:0]          i_div_r
);
    localparam int PW = $clog2(K_NREQ);
    localparam int CW = $clog2(K_TIMEOUT);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_n;
    logic [PW-1:0] last, owner, winner, idx;
    logic [CW-1:0] cnt;
    logic found;
    logic finish;
    // search starts just past the last winner so a held request is served within K_NREQ ops
    always_comb begin
        found = 1'b0;
        winner = '0;
        idx = '0;
        for (int i = 1; i <= K_NREQ; i++) begin
            idx = PW'((int'(last) + i) % K_NREQ);
            if (!found && i_req_valid[idx]) begin
                found = 1'b1;
                winner = idx;
            end
        end
    end
    // WAIT ends on a divider result or when the timeout budget is used up
    assign finish = i_div_valid || cnt == CW'(K_TIMEOUT - 1);
    always_comb begin
        state_n = state;
        o_req_ready = '0;
        o_div_start = 1'b0;
        case (state)
            IDLE: begin
                o_req_ready = found ? K_NREQ'(1) << winner : '0;
                state_n = found ? ISSUE : IDLE;
            end
            ISSUE: begin
                o_div_start = !i_div_busy;
                state_n = i_div_busy ? ISSUE : WAIT;
            end
            WAIT: state_n = finish ? RESP : WAIT;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            last <= PW'(K_NREQ - 1);
            owner <= '0;
            cnt <= '0;
            o_div_x <= '0;
            o_div_y <= '0;
            o_q <= '0;
            o_r <= '0;
            o_dbz <= 1'b0;
            o_err <= 1'b0;
            o_done <= '0;
        end else begin
            state <= state_n;
            o_done <= '0;
            if (state == IDLE && found) begin
                o_div_x <= i_req_x[int'(winner)*K_WIDTH +: K_WIDTH];
                o_div_y <= i_req_y[int'(winner)*K_WIDTH +: K_WIDTH];
                owner <= winner;
                last <= winner;
            end
            if (state == ISSUE)
                cnt <= '0;
            if (state == WAIT) begin
                cnt <= cnt + 1'b1;
                if (finish) begin
                    // a timeout reports zero results with o_err set
                    o_q <= i_div_valid ? i_div_q : '0;
                    o_r <= i_div_valid ? i_div_r : '0;
                    o_dbz <= i_div_valid && i_div_dbz;
                    o_err <= !i_div_valid;
                    o_done <= K_NREQ'(1) << owner;
                end
            end
        end
    end
endmodule

// File: tb/tb_div_share_arbiter.sv
// tb_div_share_arbiter: directed and randomized check of div_share_arbiter against a transaction-level model.
module tb_div_share_arbiter;
    localparam int N = 3;
    localparam int W = 8;
    localparam int T = 64;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_ready, done;
    logic [N*W-1:0] req_x = '0, req_y = '0;
    logic [W-1:0] o_q, o_r, div_x, div_y, div_q, div_r;
    logic o_dbz, o_err, div_start, div_busy, div_valid, div_dbz;
    div_share_arbiter #(.K_NREQ(N), .K_WIDTH(W), .K_TIMEOUT(T)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_x(req_x), .i_req_y(req_y), .o_done(done), .o_q(o_q), .o_r(o_r),
        .o_dbz(o_dbz), .o_err(o_err), .o_div_start(div_start), .o_div_x(div_x),
        .o_div_y(div_y), .i_div_busy(div_busy), .i_div_valid(div_valid),
        .i_div_dbz(div_dbz), .i_div_q(div_q), .i_div_r(div_r)
    );
    // divider stub: result appears lat cycles after start, busy in between
    int lat = 3;
    logic hang = 1'b0, late_valid = 1'b0, busy_force = 1'b0;
    int rem = 0;
    logic [W-1:0] sq = '0, sr = '0;
    logic sdbz = 1'b0;
    always @(posedge clk) begin
        if (div_start) begin
            rem <= lat;
            sq <= (div_y == 0) ? '1 : div_x / div_y;
            sr <= (div_y == 0) ? div_x : div_x % div_y;
            sdbz <= (div_y == 0);
        end else if (rem != 0)
            rem <= rem - 1;
    end
    assign div_valid = (rem == 1 && !hang) || late_valid;
    assign div_busy = rem > 1 || busy_force;
    assign div_q = sq;
    assign div_r = sr;
    assign div_dbz = sdbz;
    int vectors = 0, miscompares = 0, cyc = 0;
    bit keep = 0, rand_on = 0;
    // model state: one operation in flight, tracked by event timestamps
    int m_last = N - 1, m_owner = 0, m_start_c = 0, m_done_c = -1;
    bit m_busy = 0, m_pend = 0, m_wait = 0;
    logic [W-1:0] m_x = '0, m_y = '0, h_q = '0, h_r = '0;
    logic h_dbz = 1'b0, h_err = 1'b0;
    logic [N-1:0] acc = '0, e_ready, e_done;
    logic e_start;
    // observed DUT events for directed checks
    int a_acc_c = -1, a_start_c = -1, a_done_c = -1, a_start_n = 0, a_done_n = 0;
    logic [N-1:0] a_done_v = '0;
    logic [W-1:0] a_q = '0, a_r = '0;
    logic a_dbz = 1'b0, a_err = 1'b0;
    int a_grants[$];
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask
    task automatic check();
        if (rst) begin
            m_last = N - 1; m_busy = 0; m_pend = 0; m_wait = 0; m_done_c = -1;
            h_q = '0; h_r = '0; h_dbz = 1'b0; h_err = 1'b0; acc = '0;
            return;
        end
        e_ready = '0;
        if (!m_busy)
            for (int i = 1; i <= N; i++)
                if (e_ready == 0 && req_valid[(m_last + i) % N]) e_ready = N'(1) << ((m_last + i) % N);
        e_start = m_pend && !div_busy;
        e_done = (cyc == m_done_c) ? N'(1) << m_owner : '0;
        chk("ready", 32'(req_ready), 32'(e_ready));
        chk("start", 32'(div_start), 32'(e_start));
        chk("done", 32'(done), 32'(e_done));
        chk("q", 32'(o_q), 32'(h_q));
        chk("r", 32'(o_r), 32'(h_r));
        chk("dbz", 32'(o_dbz), 32'(h_dbz));
        chk("err", 32'(o_err), 32'(h_err));
        if (e_start) begin
            chk("div_x", 32'(div_x), 32'(m_x));
            chk("div_y", 32'(div_y), 32'(m_y));
        end
        acc = e_ready & req_valid;
        if (req_ready != 0) begin
            a_acc_c = cyc;
            for (int k = 0; k < N; k++) if (req_ready[k]) a_grants.push_back(k);
        end
        if (div_start) begin a_start_c = cyc; a_start_n++; end
        if (done != 0) begin
            a_done_n++; a_done_c = cyc; a_done_v = done;
            a_q = o_q; a_r = o_r; a_dbz = o_dbz; a_err = o_err;
        end
        if (acc != 0) begin
            m_busy = 1; m_pend = 1;
            for (int k = 0; k < N; k++) if (acc[k]) m_owner = k;
            m_last = m_owner;
            m_x = req_x[m_owner*W +: W];
            m_y = req_y[m_owner*W +: W];
        end else if (e_start) begin
            m_pend = 0; m_wait = 1; m_start_c = cyc;
        end else if (m_wait && (div_valid || cyc == m_start_c + T)) begin
            m_wait = 0; m_done_c = cyc + 1;
            h_err = !div_valid;
            h_dbz = div_valid && m_y == 0;
            h_q = !div_valid ? '0 : (m_y == 0) ? '1 : m_x / m_y;
            h_r = !div_valid ? '0 : (m_y == 0) ? m_x : m_x % m_y;
        end else if (cyc == m_done_c)
            m_busy = 0;
    endtask
    task automatic drive();
        for (int k = 0; k < N; k++) if (acc[k] && !keep) req_valid[k] = 1'b0;
        if (rand_on) begin
            rst = ($urandom_range(599) == 0);
            busy_force = ($urandom_range(7) == 0);
            lat = $urandom_range(W + 2, 1);
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k]) begin
                    if ($urandom_range(2) == 0) begin
                        req_valid[k] = 1'b1;
                        req_x[k*W +: W] = W'($urandom);
                        req_y[k*W +: W] = ($urandom_range(7) == 0) ? '0 : W'($urandom);
                    end
                end else if (!acc[k] && $urandom_range(15) == 0)
                    req_valid[k] = 1'b0;
            end
        end
    endtask
    task automatic step();
        @(negedge clk);
        check();
        @(posedge clk);
        cyc++;
        #1;
        drive();
    endtask
    task automatic req(input int k, input int x, input int y);
        req_valid[k] = 1'b1;
        req_x[k*W +: W] = W'(x);
        req_y[k*W +: W] = W'(y);
    endtask
    task automatic wait_done(input int n0, input int lim, input string nm);
        for (int i = 0; i < lim && a_done_n == n0; i++) step();
        chk(nm, 32'(a_done_n - n0), 32'd1);
        step();
    endtask
    int c0, n0, s0, g0;
    int exp_order[5] = '{0, 1, 2, 0, 1};
    initial begin
        repeat (3) step();
        rst = 1'b0;
        step();
        // single request 200/7
        lat = 5; c0 = cyc; n0 = a_done_n;
        req(0, 200, 7);
        wait_done(n0, 40, "t1_done");
        chk("t1_accept", 32'(a_acc_c - c0), 32'd0);
        chk("t1_start", 32'(a_start_c - c0), 32'd1);
        chk("t1_done_c", 32'(a_done_c - c0), 32'd7);
        chk("t1_owner", 32'(a_done_v), 32'b001);
        chk("t1_q", 32'(a_q), 32'd28);
        chk("t1_r", 32'(a_r), 32'd4);
        chk("t1_model_q", 32'(h_q), 32'd28);
        // divide by zero
        lat = 4; n0 = a_done_n;
        req(1, 50, 0);
        wait_done(n0, 40, "t3_done");
        chk("t3_owner", 32'(a_done_v), 32'b010);
        chk("t3_dbz", 32'(a_dbz), 32'd1);
        chk("t3_err", 32'(a_err), 32'd0);
        chk("t3_r", 32'(a_r), 32'd50);
        // busy held five cycles at ISSUE
        lat = 3; c0 = cyc; n0 = a_done_n; s0 = a_start_n;
        busy_force = 1'b1;
        req(0, 90, 9);
        repeat (6) step();
        busy_force = 1'b0;
        wait_done(n0, 40, "t6_done");
        chk("t6_start_c", 32'(a_start_c - c0), 32'd6);
        chk("t6_start_once", 32'(a_start_n - s0), 32'd1);
        chk("t6_q", 32'(a_q), 32'd10);
        // divider never answers
        hang = 1'b1; c0 = cyc; n0 = a_done_n;
        req(2, 9, 2);
        wait_done(n0, 100, "t4_done");
        chk("t4_done_c", 32'(a_done_c - (c0 + 2)), 32'(T));
        chk("t4_err", 32'(a_err), 32'd1);
        chk("t4_q", 32'(a_q), 32'd0);
        chk("t4_owner", 32'(a_done_v), 32'b100);
        hang = 1'b0; n0 = a_done_n;
        late_valid = 1'b1;
        step();
        late_valid = 1'b0;
        repeat (4) step();
        chk("t4_late_nodone", 32'(a_done_n), 32'(n0));
        // reset during WAIT
        lat = 20; s0 = a_start_n;
        req(2, 100, 3);
        for (int i = 0; i < 50 && a_start_n == s0; i++) step();
        repeat (3) step();
        n0 = a_done_n;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (30) step();
        chk("t5_no_done", 32'(a_done_n), 32'(n0));
        chk("t5_err", 32'(o_err), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        // all three held: strict rotation from requester 0
        keep = 1; g0 = a_grants.size();
        req(0, 100, 3); req(1, 77, 9); req(2, 13, 0);
        for (int i = 0; i < 1000 && a_grants.size() < g0 + 5; i++) step();
        chk("t2_grants", 32'(a_grants.size() >= g0 + 5), 32'd1);
        for (int i = 0; i < 5 && g0 + i < a_grants.size(); i++)
            chk("t2_order", 32'(a_grants[g0 + i]), 32'(exp_order[i]));
        keep = 0;
        req_valid = '0;
        repeat (100) step();
        // random traffic
        rand_on = 1;
        repeat (4000) step();
        rand_on = 0;
        rst = 1'b0;
        busy_force = 1'b0;
        req_valid = '0;
        repeat (200) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
